flexdpe_seq: RTL and testbench
==============================

# flexdpe_seq

Command-driven sequencer that feeds one FLEX-DPE macro PE. Per accepted command it fetches one stationary vector and a run of streaming vectors from a local operand buffer. It drives them onto the FLEX-DPE input bus with the matching `i_stationary`, `i_data_valid`, dest-bus and VN-separator controls. It then waits a fixed drain time for the reduction network to empty and signals completion.

## Interface
- `IN_DATA_TYPE`, 16, element width
- `NUM_PES`, 32, PEs per FLEX-DPE
- `LOG2_PES`, 5, log2(NUM_PES)
- `ADDR_W`, 10, operand buffer address width
- `CNT_W`, 10, stream length width
- `DRAIN_CYCLES`, 16, cycles from final beat to done (≥1)
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `i_cmd_valid` in 1 — command request
- `o_cmd_ready` out 1 — high only in IDLE
- `i_cmd_stat_addr` in ADDR_W — stationary vector address
- `i_cmd_strm_addr` in ADDR_W — first streaming vector address
- `i_cmd_strm_len` in CNT_W — number of streaming vectors, 0 allowed
- `i_cmd_dest_bus` in NUM_PES*LOG2_PES — xbar destinations for this command
- `i_cmd_vn_seperator` in NUM_PES*LOG2_PES — VN separators for this command
- `i_hold` in 1 — backpressure; suppresses new reads
- `o_mem_rd_en` out 1 — buffer read strobe
- `o_mem_rd_addr` out ADDR_W — buffer read address
- `i_mem_rd_data` in NUM_PES*IN_DATA_TYPE — read data, valid one cycle after strobe
- `o_data_valid` out 1 — to FLEX-DPE `i_data_valid`
- `o_data_bus` out NUM_PES*IN_DATA_TYPE — to FLEX-DPE `i_data_bus`
- `o_stationary` out 1 — to FLEX-DPE `i_stationary`
- `o_dest_bus` out NUM_PES*LOG2_PES — to FLEX-DPE `i_dest_bus`
- `o_vn_seperator` out NUM_PES*LOG2_PES — to FLEX-DPE `i_vn_seperator`
- `o_busy` out 1 — state ≠ IDLE
- `o_done` out 1 — one-cycle completion pulse

## Operation
- States: IDLE, LOAD, STREAM, DRAIN.
- **IDLE**
  - Command is accepted on `i_cmd_valid & o_cmd_ready`.
  - On accept, latch all command fields and go to LOAD.
  - `o_dest_bus` and `o_vn_seperator` take the latched values and hold them until the next accept. Reset clears them to 0.
- **LOAD**
  - With `i_hold`=0: assert `o_mem_rd_en` with addr=stat_addr, tag the read stationary, clear beat counter k.
  - Then go to STREAM if len>0, else DRAIN.
- **STREAM**
  - With `i_hold`=0: read addr = strm_addr+k (mod 2^ADDR_W, wraps silently), then k++.
  - After the read with k=len−1, go to DRAIN.
- **Hold:** when `i_hold`=1 in LOAD/STREAM, no read is issued and the state does not change. Reads already issued still complete.
- **Output pipe**
  - The tag and `rd_en` are delayed 2 cycles. Read data is registered one cycle after return.
  - `o_data_valid`=1 exactly 2 cycles after each strobe; `o_stationary` is set only on the LOAD beat.
  - When `o_data_valid`=0: `o_data_bus` and `o_stationary` are 0.
- **DRAIN**
  - The counter loads DRAIN_CYCLES on the final `o_data_valid` beat and decrements each cycle.
  - At 1 → `o_done`=1 for one cycle and return to IDLE. `o_cmd_ready`=1 the following cycle.
- `i_cmd_valid` outside IDLE is ignored, with no queueing.
- **Reset** (asynchronous, any time)
  - State → IDLE; counters, pipe registers and all outputs → 0, except `o_cmd_ready`=1 after reset deasserts.
  - In-flight reads are discarded and no `o_done` is issued.

## Timing
- Accept at cycle 0, no hold:
  - LOAD read at cycle 1.
  - Stream reads at cycles 2..L+1.
  - Stationary beat at cycle 3.
  - Stream beats at cycles 4..L+3.
  - `o_done` at cycle L+3+DRAIN_CYCLES.
  - Next accept possible at cycle L+4+DRAIN_CYCLES.
- L=0: single beat at cycle 3, `o_done` at 3+DRAIN_CYCLES.
- Each hold cycle during LOAD/STREAM delays all later beats and `o_done` by one cycle. Hold during DRAIN has no effect.
- Beats are contiguous and in address order; no beat is dropped or duplicated.
- `o_busy`=1 from cycle 1 through the `o_done` cycle inclusive.

## Test plan
- **Basic run:** stat_addr=5, strm_addr=100, len=3, D=16; mem[a]=a replicated.
  - Reads at cycles 1–4 for addresses 5, 100, 101, 102.
  - Beats at cycles 3–6 with data 5, 100, 101, 102; `o_stationary` only at cycle 3.
  - `o_done` at cycle 22.
- **Zero length:** len=0 → one stationary beat at cycle 3, `o_done` at cycle 19, no stream read issued.
- **Hold:** len=4, `i_hold`=1 during cycles 3–4 → reads at cycles 1, 2, 5, 6, 7; beats at cycles 3, 4, 7, 8, 9; `o_done` at cycle 25.
- **Wrap and busy:**
  - strm_addr=1022, len=4 → addresses 1022, 1023, 0, 1.
  - A second `i_cmd_valid` held high while busy is not accepted until the cycle after `o_done`.
- **Reset mid-stream:** assert `rst` at cycle 5 of a len=8 run → all outputs 0 immediately, no `o_done`. After release, a new command runs with the nominal timing.
- **Control latch:** `i_cmd_dest_bus`/`i_cmd_vn_seperator` are changed after accept → `o_dest_bus`/`o_vn_seperator` keep the accepted values until the next accept.

Source files
------------

// File: rtl/flexdpe_seq.sv
// Command-driven sequencer for one FLEX-DPE PE: fetches a stationary vector and a
// run of streaming vectors from the operand buffer and presents them as beats.
module flexdpe_seq #(
  parameter int IN_DATA_TYPE = 16,
  parameter int NUM_PES      = 32,
  parameter int LOG2_PES     = 5,
  parameter int ADDR_W       = 10,
  parameter int CNT_W        = 10,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic [ADDR_W-1:0]             i_cmd_stat_addr,
  input  logic [ADDR_W-1:0]             i_cmd_strm_addr,
  input  logic [CNT_W-1:0]              i_cmd_strm_len,
  input  logic [NUM_PES*LOG2_PES-1:0]   i_cmd_dest_bus,
  input  logic [NUM_PES*LOG2_PES-1:0]   i_cmd_vn_seperator,
  input  logic                          i_hold,
  output logic                          o_mem_rd_en,
  output logic [ADDR_W-1:0]             o_mem_rd_addr,
  input  logic [NUM_PES*IN_DATA_TYPE-1:0] i_mem_rd_data,
  output logic                          o_data_valid,
  output logic [NUM_PES*IN_DATA_TYPE-1:0] o_data_bus,
  output logic                          o_stationary,
  output logic [NUM_PES*LOG2_PES-1:0]   o_dest_bus,
  output logic [NUM_PES*LOG2_PES-1:0]   o_vn_seperator,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int DATA_W  = NUM_PES * IN_DATA_TYPE;
  localparam int CTRL_W  = NUM_PES * LOG2_PES;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   stat_addr_r;
  logic [ADDR_W-1:0]   strm_addr_r;
  logic [CNT_W-1:0]    len_r;
  logic [CNT_W-1:0]    k_r;
  logic [CTRL_W-1:0]   dest_bus_r;
  logic [CTRL_W-1:0]   vn_sep_r;
  logic                drain_armed_r;
  logic [DRAIN_W-1:0]  drain_cnt_r;
  logic                vld_d1_r;
  logic                stat_d1_r;
  logic                data_valid_r;
  logic                stationary_r;
  logic [DATA_W-1:0]   data_bus_r;
  logic                accept_s;
  logic                rd_en_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic                done_s;
  logic                arm_s;

  // Next-state, read strobe/address and completion decode.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    rd_en_s     = 1'b0;
    rd_addr_s   = '0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!i_hold) begin
          rd_en_s     = 1'b1;
          rd_addr_s   = stat_addr_r;
          state_nxt_s = (len_r != '0) ? ST_STREAM : ST_DRAIN;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_STREAM: begin
        if (!i_hold) begin
          rd_en_s   = 1'b1;
          rd_addr_s = strm_addr_r + ADDR_W'(k_r);
          if (k_r == len_r - CNT_ONE) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_STREAM;
          end
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (drain_armed_r && (drain_cnt_r == DRAIN_ONE)) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // The last beat is the one with no further read behind it in the pipe.
  assign arm_s = (state_r == ST_DRAIN) & ~drain_armed_r & data_valid_r & ~vld_d1_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Command latch, beat counter and drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_addr_r   <= '0;
      strm_addr_r   <= '0;
      len_r         <= '0;
      k_r           <= '0;
      dest_bus_r    <= '0;
      vn_sep_r      <= '0;
      drain_armed_r <= 1'b0;
      drain_cnt_r   <= '0;
    end else begin
      if (accept_s) begin
        stat_addr_r <= i_cmd_stat_addr;
        strm_addr_r <= i_cmd_strm_addr;
        len_r       <= i_cmd_strm_len;
        dest_bus_r  <= i_cmd_dest_bus;
        vn_sep_r    <= i_cmd_vn_seperator;
      end
      if (rd_en_s && (state_r == ST_LOAD)) begin
        k_r <= '0;
      end else if (rd_en_s) begin
        k_r <= k_r + CNT_ONE;
      end
      if (arm_s) begin
        drain_armed_r <= 1'b1;
        drain_cnt_r   <= DRAIN_LOAD;
      end else if (drain_armed_r && (drain_cnt_r == DRAIN_ONE)) begin
        drain_armed_r <= 1'b0;
        drain_cnt_r   <= '0;
      end else if (drain_armed_r) begin
        drain_cnt_r <= drain_cnt_r - DRAIN_ONE;
      end
    end
  end

  // Output pipe: strobe/tag delayed two cycles, returned data registered once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_d1_r     <= 1'b0;
      stat_d1_r    <= 1'b0;
      data_valid_r <= 1'b0;
      stationary_r <= 1'b0;
      data_bus_r   <= '0;
    end else begin
      vld_d1_r     <= rd_en_s;
      stat_d1_r    <= rd_en_s & (state_r == ST_LOAD);
      data_valid_r <= vld_d1_r;
      stationary_r <= vld_d1_r & stat_d1_r;
      data_bus_r   <= vld_d1_r ? i_mem_rd_data : '0;
    end
  end

  assign o_cmd_ready    = (state_r == ST_IDLE);
  assign o_busy         = (state_r != ST_IDLE);
  assign o_done         = done_s;
  assign o_mem_rd_en    = rd_en_s;
  assign o_mem_rd_addr  = rd_addr_s;
  assign o_data_valid   = data_valid_r;
  assign o_data_bus     = data_bus_r;
  assign o_stationary   = stationary_r;
  assign o_dest_bus     = dest_bus_r;
  assign o_vn_seperator = vn_sep_r;

endmodule

// File: tb/tb_flexdpe_seq.sv
// Directed self-checking bench for flexdpe_seq: timing of reads, beats and done,
// hold, address wrap, busy/ready, mid-run reset and control latching.
module tb_flexdpe_seq;

  localparam int NP  = 32;
  localparam int DT  = 16;
  localparam int LP  = 5;
  localparam int AW  = 10;
  localparam int CW  = 10;
  localparam int DC  = 16;
  localparam int DW  = NP * DT;
  localparam int CTW = NP * LP;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic [AW-1:0]  i_cmd_stat_addr;
  logic [AW-1:0]  i_cmd_strm_addr;
  logic [CW-1:0]  i_cmd_strm_len;
  logic [CTW-1:0] i_cmd_dest_bus;
  logic [CTW-1:0] i_cmd_vn_seperator;
  logic           i_hold;
  logic           o_mem_rd_en;
  logic [AW-1:0]  o_mem_rd_addr;
  logic [DW-1:0]  i_mem_rd_data;
  logic           o_data_valid;
  logic [DW-1:0]  o_data_bus;
  logic           o_stationary;
  logic [CTW-1:0] o_dest_bus;
  logic [CTW-1:0] o_vn_seperator;
  logic           o_busy;
  logic           o_done;

  flexdpe_seq #(
    .IN_DATA_TYPE(DT), .NUM_PES(NP), .LOG2_PES(LP),
    .ADDR_W(AW), .CNT_W(CW), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_stat_addr(i_cmd_stat_addr), .i_cmd_strm_addr(i_cmd_strm_addr),
    .i_cmd_strm_len(i_cmd_strm_len), .i_cmd_dest_bus(i_cmd_dest_bus),
    .i_cmd_vn_seperator(i_cmd_vn_seperator), .i_hold(i_hold),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_rd_addr(o_mem_rd_addr),
    .i_mem_rd_data(i_mem_rd_data), .o_data_valid(o_data_valid),
    .o_data_bus(o_data_bus), .o_stationary(o_stationary),
    .o_dest_bus(o_dest_bus), .o_vn_seperator(o_vn_seperator),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  localparam logic [CTW-1:0] DEST_A = {5{32'h1234_5678}};
  localparam logic [CTW-1:0] VN_A   = {5{32'h0F0F_A5A5}};
  localparam logic [CTW-1:0] DEST_B = {5{32'hCAFE_0001}};
  localparam logic [CTW-1:0] VN_B   = {5{32'h3C3C_7E01}};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int base = 0;
  int rel_m;
  bit mon_en = 1'b0;
  int rd_c[$], rd_a[$], bt_c[$], bt_d[$], bt_s[$], dn_c[$];
  bit busy_a[64];
  bit ready_a[64];
  int rep_bad, idle_bad, rst_bad, rst_seen;

  // Operand buffer model: mem[a] = a replicated, garbage when not read.
  always @(posedge clk) begin
    i_mem_rd_data <= o_mem_rd_en ? {NP{6'b0, o_mem_rd_addr}} : {NP{16'hBEEF}};
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      rel_m = cyc - base;
      if (rel_m >= 0 && rel_m < 64) begin
        busy_a[rel_m]  = o_busy;
        ready_a[rel_m] = o_cmd_ready;
      end
      if (o_mem_rd_en) begin
        rd_c.push_back(rel_m);
        rd_a.push_back(int'(o_mem_rd_addr));
      end
      if (o_data_valid) begin
        bt_c.push_back(rel_m);
        bt_d.push_back(int'(o_data_bus[DT-1:0]));
        bt_s.push_back(int'(o_stationary));
        if (o_data_bus != {NP{o_data_bus[DT-1:0]}}) rep_bad++;
      end else if (o_data_bus != '0 || o_stationary) begin
        idle_bad++;
      end
      if (o_done) dn_c.push_back(rel_m);
      if (rst) begin
        rst_seen++;
        if (o_mem_rd_en || o_data_valid || o_stationary || o_busy || o_done ||
            o_data_bus != '0 || o_dest_bus != '0 || o_vn_seperator != '0) rst_bad++;
      end
    end
  end

  task automatic chk(input string tag, input logic [CTW-1:0] got, input logic [CTW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input int sa, input int ta, input int len, input int hlo, input int hhi,
                         input int vuntil, input int rst_at, input int ncyc,
                         input logic [CTW-1:0] dest, input logic [CTW-1:0] vn);
    rd_c.delete(); rd_a.delete(); bt_c.delete(); bt_d.delete(); bt_s.delete(); dn_c.delete();
    rep_bad = 0; idle_bad = 0; rst_bad = 0; rst_seen = 0;
    for (int i = 0; i < 64; i++) begin
      busy_a[i] = 1'b0;
      ready_a[i] = 1'b0;
    end
    @(posedge clk); #1;
    i_cmd_valid        = 1'b1;
    i_cmd_stat_addr    = AW'(sa);
    i_cmd_strm_addr    = AW'(ta);
    i_cmd_strm_len     = CW'(len);
    i_cmd_dest_bus     = dest;
    i_cmd_vn_seperator = vn;
    base   = cyc;
    mon_en = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      i_cmd_valid = (c <= vuntil);
      i_hold      = (c >= hlo && c <= hhi);
      if (c == 1) begin
        i_cmd_dest_bus     = ~dest;
        i_cmd_vn_seperator = ~vn;
      end
      if (c == rst_at) rst = 1'b1;
      if (c == rst_at + 2) rst = 1'b0;
    end
    @(negedge clk); #1;
    mon_en = 1'b0;
    i_hold = 1'b0;
  endtask

  task automatic check_run(input string tag, input int nr, input int rc[8], input int ra[8],
                           input int nb, input int bc[8], input int bd[8], input int dc);
    int errs;
    chk($sformatf("%s n_reads", tag), rd_c.size(), nr);
    for (int i = 0; i < nr; i++) begin
      chk($sformatf("%s rd%0d cycle", tag, i), (i < rd_c.size()) ? rd_c[i] : -1, rc[i]);
      chk($sformatf("%s rd%0d addr", tag, i), (i < rd_a.size()) ? rd_a[i] : -1, ra[i]);
    end
    chk($sformatf("%s n_beats", tag), bt_c.size(), nb);
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("%s beat%0d cycle", tag, i), (i < bt_c.size()) ? bt_c[i] : -1, bc[i]);
      chk($sformatf("%s beat%0d data", tag, i), (i < bt_d.size()) ? bt_d[i] : -1, bd[i]);
      chk($sformatf("%s beat%0d stationary", tag, i), (i < bt_s.size()) ? bt_s[i] : -1, (i == 0) ? 1 : 0);
    end
    chk($sformatf("%s n_done", tag), dn_c.size(), 1);
    chk($sformatf("%s done cycle", tag), (dn_c.size() > 0) ? dn_c[0] : -1, dc);
    chk($sformatf("%s bus replication", tag), rep_bad, 0);
    chk($sformatf("%s idle bus zero", tag), idle_bad, 0);
    errs = 0;
    for (int c = 0; c <= dc + 1; c++) begin
      if (busy_a[c] != (c >= 1 && c <= dc)) errs++;
      if (ready_a[c] != !(c >= 1 && c <= dc)) errs++;
    end
    chk($sformatf("%s busy/ready profile", tag), errs, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s idle timeout", tag), (n < 200), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_cmd_valid = 1'b0; i_hold = 1'b0;
    i_cmd_stat_addr = '0; i_cmd_strm_addr = '0; i_cmd_strm_len = '0;
    i_cmd_dest_bus = '0; i_cmd_vn_seperator = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset cmd_ready", o_cmd_ready, 1);
    chk("reset busy", o_busy, 0);
    chk("reset data_valid", o_data_valid, 0);
    chk("reset rd_en", o_mem_rd_en, 0);
    chk("reset done", o_done, 0);
    chk("reset dest_bus", o_dest_bus, '0);
    chk("reset vn_sep", o_vn_seperator, '0);

    // Basic run; command control fields change after accept.
    run_cmd(5, 100, 3, 0, -1, 0, -10, 24, DEST_A, VN_A);
    check_run("basic", 4, '{1, 2, 3, 4, 0, 0, 0, 0}, '{5, 100, 101, 102, 0, 0, 0, 0},
              4, '{3, 4, 5, 6, 0, 0, 0, 0}, '{5, 100, 101, 102, 0, 0, 0, 0}, 22);
    chk("latch dest kept", o_dest_bus, DEST_A);
    chk("latch vn kept", o_vn_seperator, VN_A);

    // Zero-length run also latches a new control set.
    run_cmd(9, 300, 0, 0, -1, 0, -10, 22, DEST_B, VN_B);
    check_run("zero_len", 1, '{1, 0, 0, 0, 0, 0, 0, 0}, '{9, 0, 0, 0, 0, 0, 0, 0},
              1, '{3, 0, 0, 0, 0, 0, 0, 0}, '{9, 0, 0, 0, 0, 0, 0, 0}, 19);
    chk("latch dest updated", o_dest_bus, DEST_B);
    chk("latch vn updated", o_vn_seperator, VN_B);

    // Hold during cycles 3-4, then hold again during drain (no effect).
    run_cmd(20, 40, 4, 3, 4, 0, -10, 28, DEST_A, VN_A);
    check_run("hold", 5, '{1, 2, 5, 6, 7, 0, 0, 0}, '{20, 40, 41, 42, 43, 0, 0, 0},
              5, '{3, 4, 7, 8, 9, 0, 0, 0}, '{20, 40, 41, 42, 43, 0, 0, 0}, 25);
    run_cmd(21, 50, 1, 5, 12, 0, -10, 24, DEST_A, VN_A);
    check_run("drain_hold", 2, '{1, 2, 0, 0, 0, 0, 0, 0}, '{21, 50, 0, 0, 0, 0, 0, 0},
              2, '{3, 4, 0, 0, 0, 0, 0, 0}, '{21, 50, 0, 0, 0, 0, 0, 0}, 20);

    // Address wrap; valid held high is accepted only after done.
    run_cmd(7, 1022, 4, 0, -1, 24, -10, 25, DEST_A, VN_A);
    check_run("wrap", 6, '{1, 2, 3, 4, 5, 25, 0, 0}, '{7, 1022, 1023, 0, 1, 7, 0, 0},
              5, '{3, 4, 5, 6, 7, 0, 0, 0}, '{7, 1022, 1023, 0, 1, 0, 0, 0}, 23);
    chk("wrap second busy", busy_a[25], 1);
    wait_idle("wrap");

    // Reset in the middle of a len=8 run.
    run_cmd(3, 200, 8, 0, -1, 0, 5, 30, DEST_B, VN_B);
    chk("midrst samples", rst_seen, 2);
    chk("midrst outputs zero", rst_bad, 0);
    chk("midrst no done", dn_c.size(), 0);
    chk("midrst busy after", busy_a[9], 0);
    chk("midrst ready after", ready_a[9], 1);

    // Nominal timing after reset.
    run_cmd(5, 100, 3, 0, -1, 0, -10, 24, DEST_A, VN_A);
    check_run("post_rst", 4, '{1, 2, 3, 4, 0, 0, 0, 0}, '{5, 100, 101, 102, 0, 0, 0, 0},
              4, '{3, 4, 5, 6, 0, 0, 0, 0}, '{5, 100, 101, 102, 0, 0, 0, 0}, 22);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
